// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: 32-bit valid/ready framing around the AES cipher core (key/text in, result out).
// Define AES_CBC_EN to XOR each text block with the previous cipher result.
module aes_stream_ctrl #(
    parameter int TIMEOUT = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_is_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         aes_ld,
    output logic [127:0] aes_key,
    output logic [127:0] aes_text_in,
    input  logic         aes_done,
    input  logic [127:0] aes_text_out,
    output logic         err_nokey,
    output logic         err_timeout
);
    typedef enum logic [1:0] {COLLECT, START, WAIT, DRAIN} state_t;
    state_t       state, state_d;
    logic [1:0]   wcnt, k;
    logic         is_key_q, key_valid;
    logic [95:0]  acc, res;
    logic [7:0]   tmo_cnt;
    logic [127:0] chain_mask;
    logic         accept, grp_key, last_word, key_done, text_go, text_drop, xfer, tmo_hit, cap;

    assign accept    = in_valid & in_ready;
    assign grp_key   = wcnt == 2'd0 ? in_is_key : is_key_q;
    assign last_word = accept & (wcnt == 2'd3);
    assign key_done  = last_word & grp_key;
    assign text_go   = last_word & ~grp_key & key_valid;
    assign text_drop = last_word & ~grp_key & ~key_valid;
    assign xfer      = out_valid & out_ready;
    assign tmo_hit   = tmo_cnt == 8'(TIMEOUT);
    // A done arriving in the cycle the counter hits TIMEOUT is too late: the error already fired.
    assign cap       = (state == WAIT) & aes_done & ~tmo_hit;

    always_comb begin
        state_d = state;
        case (state)
            COLLECT: state_d = text_go ? START : COLLECT;
            START:   state_d = WAIT;
            WAIT:    state_d = tmo_hit ? COLLECT : cap ? DRAIN : WAIT;
            DRAIN:   state_d = xfer && k == 2'd3 ? COLLECT : DRAIN;
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= COLLECT;
            in_ready    <= 1'b0;
            aes_ld      <= 1'b0;
            out_valid   <= 1'b0;
            err_nokey   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            in_ready    <= state_d == COLLECT;
            aes_ld      <= state_d == START;
            out_valid   <= state_d == DRAIN;
            err_nokey   <= text_drop;
            err_timeout <= state == WAIT && tmo_cnt == 8'(TIMEOUT - 1) && !aes_done;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt        <= '0;
            is_key_q    <= 1'b0;
            key_valid   <= 1'b0;
            acc         <= '0;
            aes_key     <= '0;
            aes_text_in <= '0;
            tmo_cnt     <= '0;
            res         <= '0;
            k           <= '0;
            out_data    <= '0;
            out_last    <= 1'b0;
        end else begin
            if (accept) begin
                wcnt <= wcnt + 2'd1;
                acc  <= {acc[63:0], in_data};
                if (wcnt == 2'd0) is_key_q <= in_is_key;
            end
            if (key_done) begin
                aes_key   <= {acc, in_data};
                key_valid <= 1'b1;
            end
            if (text_go) aes_text_in <= {acc, in_data} ^ chain_mask;
            tmo_cnt <= state == START ? 8'd1 : tmo_cnt + 8'd1;
            if (cap) begin
                res      <= aes_text_out[95:0];
                out_data <= aes_text_out[127:96];
                out_last <= 1'b0;
                k        <= '0;
            end else if (xfer) begin
                res      <= {res[63:0], 32'd0};
                out_data <= res[95:64];
                out_last <= k == 2'd2;
                k        <= k + 2'd1;
            end
        end
    end

`ifdef AES_CBC_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) chain_mask <= '0;
        else if (key_done) chain_mask <= '0;
        else if (cap) chain_mask <= aes_text_out;
    end
`else
    assign chain_mask = '0;
`endif
endmodule

// File: doc/aes_stream_ctrl.md
Name: aes_stream_ctrl

Overview:
Stream front/back-end for the AES cipher core (aes_cipher_top). Accepts 32-bit words over a valid/ready input stream and assembles 128-bit key and plaintext blocks. Launches the core with a one-cycle load pulse, waits for done, captures the 128-bit result and returns it as four 32-bit words on a valid/ready output stream. It is both the upstream feeder of the core's key/text_in/ld and the downstream consumer of its text_out/done.

Parameters:
TIMEOUT, 32, cycles to wait for aes_done after aes_ld before aborting (range 16..255)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid & in_ready
in_data  in  32  input word
in_is_key  in  1  sampled on first word of a group: 1 = key group, 0 = text group
out_valid  out  1  output word valid
out_ready  in  1  sink accepts output word
out_data  out  32  output word
out_last  out  1  marks 4th output word
aes_ld  out  1  one-cycle load strobe to cipher core
aes_key  out  128  key to cipher core
aes_text_in  out  128  block to cipher core
aes_done  in  1  cipher core done pulse
aes_text_out  in  128  cipher core result
err_nokey  out  1  one-cycle pulse: text block dropped, no key loaded
err_timeout  out  1  one-cycle pulse: aes_done not seen within TIMEOUT

Behaviour:
- Reset (rst low, async): state COLLECT, word count 0, key_valid 0, key/text/result regs 0. All outputs 0, including in_ready. in_ready rises in the first cycle after rst deasserts; all outputs are registered.
- States: COLLECT, START, WAIT, DRAIN.
- COLLECT: in_ready=1. Accepted words fill a 2-bit counter. Group type is latched from in_is_key on word 0; in_is_key on words 1-3 is ignored. Word 0 lands in bits [127:96], word 3 in [31:0].
- On the 4th accepted word of a key group: key reg updated, key_valid=1, counter to 0, stay in COLLECT.
- On the 4th accepted word of a text group:
  - If key_valid=1: go to START, in_ready=0 next cycle.
  - If key_valid=0: block discarded, err_nokey pulses next cycle, stay in COLLECT.
- START: aes_ld=1 for exactly one cycle (the cycle after the 4th text word is accepted); go to WAIT. aes_key and aes_text_in are stable from START until return to COLLECT.
- WAIT: cycle counter runs from 1 in the cycle after aes_ld.
  - On aes_done=1: capture aes_text_out, go to DRAIN.
  - If the counter reaches TIMEOUT without done: err_timeout pulses, go to COLLECT, no output produced.
  - aes_done in any state other than WAIT is ignored.
- DRAIN: out_valid=1, out_data = result word k (k=0..3, MSW first), out_last=1 when k=3. k advances only on out_valid & out_ready. out_data/out_last are held stable while stalled. After the 4th transfer, out_valid=0 and state returns to COLLECT with in_ready=1 next cycle.
- No input accepted in START/WAIT/DRAIN (in_ready=0). A partially collected group persists indefinitely in COLLECT.
- Reset mid-operation: immediate return to reset values; key_valid cleared, any pending result discarded.

Optional Feature:
AES_CBC_EN
- Defined:
  - Adds a 128-bit chain reg, reset 0, cleared on every completed key group.
  - aes_text_in = text reg XOR chain reg.
  - Chain reg loads the captured aes_text_out on each aes_done in WAIT; a timeout leaves it unchanged.
- Undefined: no chain reg; aes_text_in = text reg.

Test Plan:
1. Reset → all outputs 0 while rst=0. in_ready=1 one cycle after rst=1; out_valid, aes_ld, err_* stay 0.
2. Key group 00010203,04050607,08090a0b,0c0d0e0f (in_is_key=1 on first word), then text group 00112233,44556677,8899aabb,ccddeeff. Core model asserts aes_done 12 cycles after aes_ld with text_out 69c4e0d86a7b0430d8cdb78070b4c55a. Required response:
   - aes_key=000102…0f.
   - aes_text_in=00112233…eeff.
   - Single-cycle aes_ld.
   - Outputs 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a with out_last on the last.
3. Text group immediately after reset (no key) → err_nokey single pulse, no aes_ld, in_ready stays 1.
4. Valid key and text, aes_done never asserted → err_timeout pulse exactly 32 cycles after aes_ld, out_valid never 1, in_ready=1 the following cycle.
5. Test 2 with out_ready low 5 cycles then alternating 1/0 → out_data stable while stalled, exactly 4 transfers, in_ready stays 0 until the final one.
6. rst pulsed low during WAIT → outputs 0 at once; a late aes_done is ignored; the next text group yields err_nokey.
